// File: rtl/arb_req_pkg.sv
// -----------------------------------------------------------------------------
// arb_req_pkg
// Shared types and helpers for the requester bank that feeds a fixed priority
// arbiter.
//   chan_state_e : per-channel FSM state (IDLE / REQ / XFER)
//   cnt_width()  : smallest counter width able to hold values 0..max_val
//   XFER_CNT_W / WAIT_CNT_W : counter widths for the default configuration
//                             (XFER_LEN = 2, STARVE_LIMIT = 16)
// -----------------------------------------------------------------------------
package arb_req_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } chan_state_e;

    // Width for a counter that must hold 0..max_val (never narrower than 1).
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    localparam int DEF_XFER_LEN     = 2;
    localparam int DEF_STARVE_LIMIT = 16;

    // The transfer counter holds XFER_LEN-1 down to 0; the wait counter
    // saturates at STARVE_LIMIT.
    localparam int XFER_CNT_W = cnt_width(DEF_XFER_LEN - 1);
    localparam int WAIT_CNT_W = cnt_width(DEF_STARVE_LIMIT);

endpackage

// File: rtl/arb_req_channel.sv
// -----------------------------------------------------------------------------
// arb_req_channel
// One requester channel: pending-job counter, IDLE/REQ/XFER FSM, transfer
// length counter, starvation wait counter and sticky overflow flag.
// Ports:
//   clk_i      : clock, rising edge
//   rst_i      : synchronous active-high reset
//   push_i     : one-cycle job enqueue strobe
//   gnt_i      : grant from the arbiter (only honoured in REQ)
//   req_o      : request to the arbiter, high exactly in REQ
//   busy_o     : high while in XFER
//   done_o     : one-cycle pulse on the last XFER cycle
//   starve_o   : high while in REQ with the wait counter saturated
//   overflow_o : sticky, set when a push is dropped on a full counter
// -----------------------------------------------------------------------------
module arb_req_channel
    import arb_req_pkg::*;
#(
    parameter int CNT_W        = 4,
    parameter int XFER_LEN     = 2,
    parameter int STARVE_LIMIT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  logic gnt_i,
    output logic req_o,
    output logic busy_o,
    output logic done_o,
    output logic starve_o,
    output logic overflow_o
);

    localparam int XW = cnt_width(XFER_LEN - 1);
    localparam int WW = cnt_width(STARVE_LIMIT);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [XW-1:0]    XFER_LOAD = XW'(XFER_LEN - 1);
    localparam logic [WW-1:0]    WAIT_MAX  = WW'(STARVE_LIMIT);

    chan_state_e      state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [XW-1:0]    xfer_reg, xfer_next;
    logic [WW-1:0]    wait_reg, wait_next;
    logic             ovf_reg, ovf_next;
    logic             take;

    always_comb begin
        // A grant consumes one pending job; the counter is never zero in REQ,
        // but the guard keeps it from wrapping under any input sequence.
        take       = (state_reg == REQ) && gnt_i && (cnt_reg != '0);

        cnt_next   = cnt_reg;
        ovf_next   = ovf_reg;
        if (push_i && !take) begin
            if (cnt_reg == CNT_MAX)
                ovf_next = 1'b1;
            else
                cnt_next = cnt_reg + CNT_W'(1);
        end else if (!push_i && take) begin
            cnt_next = cnt_reg - CNT_W'(1);
        end

        state_next = state_reg;
        xfer_next  = xfer_reg;
        wait_next  = wait_reg;
        case (state_reg)
            IDLE: begin
                // In IDLE the counter is zero, so cnt_next != 0 means a push
                // arrived (or jobs were somehow left pending).
                if (cnt_next != '0)
                    state_next = REQ;
            end
            REQ: begin
                if (gnt_i) begin
                    state_next = XFER;
                    xfer_next  = XFER_LOAD;
                    wait_next  = '0;
                end else if (wait_reg != WAIT_MAX) begin
                    wait_next = wait_reg + WW'(1);
                end
            end
            XFER: begin
                if (xfer_reg == '0)
                    state_next = (cnt_next != '0) ? REQ : IDLE;
                else
                    xfer_next = xfer_reg - XW'(1);
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            xfer_reg  <= '0;
            wait_reg  <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            xfer_reg  <= xfer_next;
            wait_reg  <= wait_next;
            ovf_reg   <= ovf_next;
        end
    end

    // All outputs decode registered state only.
    assign req_o      = (state_reg == REQ);
    assign busy_o     = (state_reg == XFER);
    assign done_o     = (state_reg == XFER) && (xfer_reg == '0);
    assign starve_o   = (state_reg == REQ) && (wait_reg == WAIT_MAX);
    assign overflow_o = ovf_reg;

endmodule

// File: rtl/arb_requester_bank.sv
// -----------------------------------------------------------------------------
// arb_requester_bank
// Bank of NUM_PORTS independent requester channels facing a fixed priority
// arbiter, plus an optional grant protocol checker.
// Optional feature macro: ARB_REQ_CHECK_EN
//   defined   : gnt_err_o sets (sticky until reset) when gnt_i has more than
//               one bit set, or grants a channel whose req_o is low
//   undefined : gnt_err_o is tied low and no check logic exists
// Ports:
//   clk_i, rst_i : clock (rising edge), synchronous active-high reset
//   push_i       : per-channel job enqueue strobes
//   gnt_i        : grant vector from the arbiter
//   req_o        : registered request vector to the arbiter
//   busy_o       : per-channel transfer-in-progress
//   done_o       : per-channel last-transfer-cycle pulse
//   starve_o     : per-channel starvation level
//   overflow_o   : per-channel sticky dropped-push flag
//   gnt_err_o    : sticky protocol error flag
// -----------------------------------------------------------------------------
module arb_requester_bank
    import arb_req_pkg::*;
#(
    parameter int NUM_PORTS    = 5,
    parameter int CNT_W        = 4,
    parameter int XFER_LEN     = DEF_XFER_LEN,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_PORTS-1:0] push_i,
    input  logic [NUM_PORTS-1:0] gnt_i,
    output logic [NUM_PORTS-1:0] req_o,
    output logic [NUM_PORTS-1:0] busy_o,
    output logic [NUM_PORTS-1:0] done_o,
    output logic [NUM_PORTS-1:0] starve_o,
    output logic [NUM_PORTS-1:0] overflow_o,
    output logic                 gnt_err_o
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_chan
            arb_req_channel #(
                .CNT_W        (CNT_W),
                .XFER_LEN     (XFER_LEN),
                .STARVE_LIMIT (STARVE_LIMIT)
            ) u_chan (
                .clk_i      (clk_i),
                .rst_i      (rst_i),
                .push_i     (push_i[gi]),
                .gnt_i      (gnt_i[gi]),
                .req_o      (req_o[gi]),
                .busy_o     (busy_o[gi]),
                .done_o     (done_o[gi]),
                .starve_o   (starve_o[gi]),
                .overflow_o (overflow_o[gi])
            );
        end
    endgenerate

`ifdef ARB_REQ_CHECK_EN
    logic gnt_err_reg;
    logic multi_gnt;
    logic stray_gnt;

    // x & (x-1) clears the lowest set bit; anything left means two or more.
    assign multi_gnt = (gnt_i & (gnt_i - NUM_PORTS'(1))) != '0;
    assign stray_gnt = (gnt_i & ~req_o) != '0;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            gnt_err_reg <= 1'b0;
        else if (multi_gnt || stray_gnt)
            gnt_err_reg <= 1'b1;
    end

    assign gnt_err_o = gnt_err_reg;
`else
    assign gnt_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_arb_requester_bank.sv
// -----------------------------------------------------------------------------
// tb_arb_requester_bank
// Directed phases followed by a randomized phase, every cycle compared against
// a job-level reference model (pending job count, remaining transfer cycles,
// cycles spent waiting for a grant).
// -----------------------------------------------------------------------------
module tb_arb_requester_bank;

    localparam int NP       = 5;
    localparam int CW       = 4;
    localparam int XL       = 2;
    localparam int SL       = 16;
    localparam int PEND_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic [NP-1:0] push_i = '0;
    logic [NP-1:0] gnt_i = '0;
    logic [NP-1:0] req_o, busy_o, done_o, starve_o, overflow_o;
    logic          gnt_err_o;

    always #5 clk = ~clk;

    arb_requester_bank #(
        .NUM_PORTS    (NP),
        .CNT_W        (CW),
        .XFER_LEN     (XL),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .push_i     (push_i),
        .gnt_i      (gnt_i),
        .req_o      (req_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .starve_o   (starve_o),
        .overflow_o (overflow_o),
        .gnt_err_o  (gnt_err_o)
    );

    int checks   = 0;
    int failures = 0;
    int done_seen[NP];

    // Reference model: jobs waiting, transfer cycles still to run (0 = none),
    // whether the channel is asking for a grant, and how long it has waited.
    int m_pend[NP];
    int m_xfer[NP];
    int m_wait[NP];
    bit m_asking[NP];
    bit m_ovf[NP];
    bit m_err;
    bit m_valid = 1'b0;

    task automatic check_outputs();
        logic [NP-1:0] e_req, e_busy, e_done, e_starve, e_ovf;
        logic          e_err;
        for (int i = 0; i < NP; i++) begin
            e_req[i]    = m_asking[i];
            e_busy[i]   = (m_xfer[i] > 0);
            e_done[i]   = (m_xfer[i] == 1);
            e_starve[i] = m_asking[i] && (m_wait[i] >= SL);
            e_ovf[i]    = m_ovf[i];
        end
        e_err = m_err;
        checks++;
        assert (req_o === e_req) else begin
            failures++; $error("FAIL req_o t=%0t got=%b exp=%b", $time, req_o, e_req);
        end
        checks++;
        assert (busy_o === e_busy) else begin
            failures++; $error("FAIL busy_o t=%0t got=%b exp=%b", $time, busy_o, e_busy);
        end
        checks++;
        assert (done_o === e_done) else begin
            failures++; $error("FAIL done_o t=%0t got=%b exp=%b", $time, done_o, e_done);
        end
        checks++;
        assert (starve_o === e_starve) else begin
            failures++; $error("FAIL starve_o t=%0t got=%b exp=%b", $time, starve_o, e_starve);
        end
        checks++;
        assert (overflow_o === e_ovf) else begin
            failures++; $error("FAIL overflow_o t=%0t got=%b exp=%b", $time, overflow_o, e_ovf);
        end
        checks++;
        assert (gnt_err_o === e_err) else begin
            failures++; $error("FAIL gnt_err_o t=%0t got=%b exp=%b", $time, gnt_err_o, e_err);
        end
        for (int i = 0; i < NP; i++)
            if (done_o[i] === 1'b1) done_seen[i]++;
    endtask

    task automatic model_edge(input logic [NP-1:0] p, input logic [NP-1:0] g, input logic r);
        logic [NP-1:0] asking_vec;
        bit            taking;
        if (r) begin
            for (int i = 0; i < NP; i++) begin
                m_pend[i] = 0; m_xfer[i] = 0; m_wait[i] = 0;
                m_asking[i] = 0; m_ovf[i] = 0;
            end
            m_err   = 0;
            m_valid = 1;
            return;
        end
`ifdef ARB_REQ_CHECK_EN
        for (int i = 0; i < NP; i++) asking_vec[i] = m_asking[i];
        if ($countones(g) > 1 || (g & ~asking_vec) != '0) m_err = 1;
`else
        asking_vec = '0;
`endif
        for (int i = 0; i < NP; i++) begin
            taking = m_asking[i] && g[i];
            if (p[i] && !taking) begin
                if (m_pend[i] == PEND_MAX) m_ovf[i] = 1;
                else m_pend[i]++;
            end else if (taking && !p[i]) begin
                m_pend[i]--;
            end
            if (m_asking[i]) begin
                if (g[i]) begin
                    m_asking[i] = 0; m_xfer[i] = XL; m_wait[i] = 0;
                end else if (m_wait[i] < SL) begin
                    m_wait[i]++;
                end
            end else if (m_xfer[i] > 0) begin
                m_xfer[i]--;
                if (m_xfer[i] == 0) m_asking[i] = (m_pend[i] > 0);
            end else begin
                m_asking[i] = (m_pend[i] > 0);
            end
        end
    endtask

    // One clock: check current outputs, apply inputs, advance the model.
    task automatic step(input logic [NP-1:0] p, input logic [NP-1:0] g, input logic r);
        @(negedge clk);
        if (m_valid) check_outputs();
        push_i = p;
        gnt_i  = g;
        rst_i  = r;
        @(posedge clk);
        model_edge(p, g, r);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step('0, '0, 1'b0);
    endtask

    task automatic clear_done();
        for (int i = 0; i < NP; i++) done_seen[i] = 0;
    endtask

`ifdef ARB_REQ_CHECK_EN
    a_err_set: assert property (@(posedge clk) disable iff (rst_i)
        (($countones(gnt_i) > 1) || ((gnt_i & ~req_o) != '0)) |=> gnt_err_o)
        else begin failures++; $error("FAIL a_err_set t=%0t", $time); end
    a_err_hold: assert property (@(posedge clk) disable iff (rst_i)
        gnt_err_o |=> gnt_err_o)
        else begin failures++; $error("FAIL a_err_hold t=%0t", $time); end
`endif

    initial begin
        logic [NP-1:0] p, g;
        int            mode;
        clear_done();

        // Reset for three cycles, then twenty idle cycles.
        for (int k = 0; k < 3; k++) step('0, '0, 1'b1);
        idle(20);

        // Single job on port 2, granted two cycles after req rises.
        step(5'b00100, '0, 1'b0);
        idle(2);
        step('0, 5'b00100, 1'b0);
        idle(6);

        // Three back-to-back jobs on port 0 with the grant held high.
        clear_done();
        for (int k = 0; k < 3; k++) step(5'b00001, 5'b00001, 1'b0);
        for (int k = 0; k < 12; k++) step('0, 5'b00001, 1'b0);
        idle(3);
        checks++;
        assert (done_seen[0] == 3) else begin
            failures++; $error("FAIL done_count_p0 got=%0d exp=3", done_seen[0]);
        end

        // Sixteen pushes on port 1 (one dropped), then grant until drained.
        step('0, '0, 1'b1);
        clear_done();
        for (int k = 0; k < 16; k++) step(5'b00010, '0, 1'b0);
        for (int k = 0; k < 55; k++) step('0, 5'b00010, 1'b0);
        idle(3);
        checks++;
        assert (done_seen[1] == 15) else begin
            failures++; $error("FAIL done_count_p1 got=%0d exp=15", done_seen[1]);
        end

        // Starvation on port 4: twenty un-granted cycles, then a grant.
        step('0, '0, 1'b1);
        step(5'b10000, '0, 1'b0);
        idle(20);
        step('0, 5'b10000, 1'b0);
        idle(5);

        // Randomized traffic with occasional mid-flight resets.
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < NP; i++) p[i] = ($urandom_range(0, 3) == 0);
            mode = $urandom_range(0, 9);
            g = '0;
            if (mode < 6) begin
                for (int i = 0; i < NP; i++)
                    if (m_asking[i] && g == '0) g[i] = 1'b1;
            end else if (mode >= 8) begin
                g = NP'($urandom_range(0, (1 << NP) - 1));
            end
            step(p, g, ($urandom_range(0, 99) == 0));
        end

        // Protocol error: two grants with nothing requesting.
        step('0, '0, 1'b1);
        idle(2);
        step('0, 5'b00011, 1'b0);
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arb_requester_bank.md
Name: arb_requester_bank

Overview:
- Requester-side counterpart to the fixed priority arbiter. Holds N independent request channels.
- Each channel queues pending jobs as a counter and drives req_o to the arbiter. On each grant it runs a fixed-length transfer, then re-requests while jobs remain.
- Sits between job sources and the arbiter's req/gnt interface. Also flags starvation and protocol errors.

Parameters:
- NUM_PORTS, 5, number of channels; must match the arbiter.
- CNT_W, 4, width of each pending-job counter; max 2^CNT_W-1 jobs.
- XFER_LEN, 2, transfer length in cycles after a grant; must be ≥1.
- STARVE_LIMIT, 16, consecutive un-granted REQ cycles before starve_o asserts.

Ports:
- clk_i, input, 1, system clock; all logic is on the rising edge.
- rst_i, input, 1, synchronous active-high reset.
- push_i, input, NUM_PORTS, per-channel one-cycle job enqueue strobe.
- gnt_i, input, NUM_PORTS, grant vector from the arbiter.
- req_o, output, NUM_PORTS, registered request vector to the arbiter.
- busy_o, output, NUM_PORTS, high while a channel is in XFER.
- done_o, output, NUM_PORTS, one-cycle pulse on the last XFER cycle.
- starve_o, output, NUM_PORTS, level; high while a channel is starved.
- overflow_o, output, NUM_PORTS, sticky; set when a push is dropped.
- gnt_err_o, output, 1, sticky protocol-error flag (see Optional Feature).

Behaviour:
- Reset (rst_i high at an edge): all outputs 0, counters 0, every channel in IDLE.
  - Reset mid-XFER aborts the transfer with no done_o pulse.
  - Pending jobs are discarded.
- Per-channel FSM, states IDLE / REQ / XFER; req_o[p] is 1 exactly in REQ.
- IDLE:
  - If (cnt != 0 or push_i[p]), go to REQ.
  - A push at edge t gives req_o high at t+1.
- REQ:
  - gnt_i[p] is sampled at each edge.
  - If high: go to XFER, decrement cnt, load xfer counter with XFER_LEN-1, clear the wait counter. req_o drops the next cycle.
  - If low: wait counter increments, saturating at STARVE_LIMIT.
  - starve_o[p] = (wait counter == STARVE_LIMIT) and state is REQ.
- XFER:
  - busy_o high; the xfer counter decrements.
  - On the cycle the counter is 0, done_o pulses. Next state is REQ if the next cnt is nonzero, else IDLE.
  - Cycle timing for a grant at edge t: busy_o is high t+1 .. t+XFER_LEN, done_o is high at t+XFER_LEN, and req_o returns at t+XFER_LEN+1 if jobs remain.
- Counter rules:
  - Push and grant-decrement in the same cycle leave cnt unchanged.
  - Push with cnt = max and no decrement: push dropped, overflow_o[p] set until reset.
  - cnt never wraps.
- gnt_i[p] while the channel is not in REQ is ignored by the FSM. There is no re-arbitration inside XFER.
- Channels are fully independent; multiple simultaneous grants are each honoured locally.

Optional Feature:
- Macro ARB_REQ_CHECK_EN.
- Defined: gnt_err_o is set and held until reset when either condition holds at an edge:
  - gnt_i is not $onehot0;
  - any gnt_i[p] is high while req_o[p] is 0.
- Defined: the bench also enables the matching concurrent assertions.
- Undefined: gnt_err_o is tied to 0 and no check logic is generated. Functional behaviour is otherwise identical.

Decomposition:
- Package arb_req_pkg holds:
  - typedef enum logic [1:0] {IDLE, REQ, XFER} chan_state_e;
  - localparam widths derived via $clog2 for the xfer and wait counters.
- Sub-module arb_req_channel implements one channel: FSM, pending counter, xfer counter, wait counter, overflow flag.
- The top generates NUM_PORTS instances plus the shared gnt_err_o check logic.

Test Plan:
- Reset, then idle: rst_i high 3 cycles, no pushes → req_o = 0, busy_o = 0, all flags 0 for 20 cycles.
- Single job: push_i[2] at edge t, gnt_i = 5'b00100 at edge t+3 (XFER_LEN = 2) → req_o = 5'b00100 from t+1 to t+3; busy_o[2] high at t+4 and t+5; done_o[2] at t+5; req_o returns to 0 at t+4 and stays 0.
- Back-to-back jobs: 3 pushes on port 0, grant held high → port 0 completes 3 transfers, req_o[0] re-asserts 1 cycle after each done_o, with total done_o count = 3, and req_o[0] returns to 0 after the third done_o.
- Overflow: 16 pushes on port 1 with no grant → cnt saturates at 15, overflow_o[1] = 1, and exactly 15 done_o pulses follow once grants are given.
- Starvation: port 4 requesting, no grant for 16 cycles → starve_o[4] = 1 from the 17th REQ cycle; grant → starve_o[4] = 0 the next cycle.
- ARB_REQ_CHECK_EN defined: gnt_i = 5'b00011 → gnt_err_o = 1 the next cycle and stays 1. Macro undefined: gnt_err_o stays 0.
